// File: rtl/timebase_pkg.sv
// Shared definitions for the time-base controller: FSM encodings and counter-width helpers.
package timebase_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FREE   = 2'd1,
        ST_ARMED  = 2'd2,
        ST_LOCKED = 2'd3
    } tb_state_e;

    localparam int STATE_W = 2;

    // Minimum width holding values 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_P_W = cnt_w(100000);
    localparam int DEF_M_W = cnt_w(1000);

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a registered rising-edge pulse.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_pulse;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_s1    <= i_async;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_pulse <= r_s2 & ~r_s3;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/timebase_sync_controller.sv
// ms / second tick generator disciplined to a 1PPS reference (IDLE/FREE/ARMED/LOCKED).
// Optional build macro TIMEBASE_DRIFT_CORRECT_EN: good PPS edges in LOCKED also realign the counters.
module timebase_sync_controller
    import timebase_pkg::*;
#(
    parameter int MS_DIV      = 100000,
    parameter int SEC_DIV     = 1000,
    parameter int WIN         = 2,
    parameter int MISS_MAX    = 3,
    parameter int ARM_TIMEOUT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_run,
    input  logic               i_arm,
    input  logic               i_sync_in,
    output logic               o_tick_ms,
    output logic               o_tick_sec,
    output logic               o_locked,
    output logic               o_sync_fail,
    output logic               o_lost,
    output logic [STATE_W-1:0] o_state
);

    localparam int P_W    = cnt_w(MS_DIV);
    localparam int M_W    = cnt_w(SEC_DIV);
    localparam int MISS_W = cnt_w(MISS_MAX + 1);
    localparam int ARM_W  = cnt_w(ARM_TIMEOUT + 1);

    localparam logic [P_W-1:0]    P_LAST   = P_W'(MS_DIV - 1);
    localparam logic [M_W-1:0]    M_LAST   = M_W'(SEC_DIV - 1);
    localparam logic [M_W-1:0]    M_EARLY  = M_W'(SEC_DIV - WIN);
    localparam logic [M_W-1:0]    M_WIN    = M_W'(WIN);
    localparam logic [M_W-1:0]    M_CLOSE  = M_W'(WIN - 1);
    localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MISS_MAX);
    localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);

    tb_state_e         r_state, w_state_next;
    logic [P_W-1:0]    r_p, w_p_next;
    logic [M_W-1:0]    r_m, w_m_next;
    logic [MISS_W-1:0] r_miss, w_miss_next, w_miss_sat;
    logic [ARM_W-1:0]  r_arm_cnt, w_arm_cnt_next;
    logic              r_pps_seen, w_pps_seen_next;
    logic              r_tick_ms, w_tick_ms_next;
    logic              r_tick_sec, w_tick_sec_next;
    logic              r_locked, w_locked_next;
    logic              r_sync_fail, w_sync_fail_next;
    logic              r_lost, w_lost_next;

    logic w_pe;
    logic w_wrap, w_sec_wrap, w_close, w_timeout;
    logic w_in_early, w_in_late, w_good, w_bad, w_miss_inc, w_loss;

    sync_edge_detect u_pps_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_sync_in),
        .o_pulse (w_pe)
    );

    assign w_wrap     = (r_p == P_LAST);
    assign w_sec_wrap = w_wrap && (r_m == M_LAST);
    assign w_close    = w_wrap && (r_m == M_CLOSE);
    assign w_timeout  = w_sec_wrap && (r_arm_cnt == ARM_LAST);
    assign w_in_early = (r_m >= M_EARLY);
    assign w_in_late  = (r_m < M_WIN);
    assign w_good     = w_pe && (w_in_early || w_in_late);
    assign w_bad      = w_pe && !(w_in_early || w_in_late);
    // A bad edge and a missed window close in the same cycle still count as one miss.
    assign w_miss_inc = w_bad || (w_close && !(r_pps_seen || w_good));
    assign w_miss_sat = (r_miss == MISS_LIM) ? r_miss : r_miss + MISS_W'(1);
    assign w_loss     = w_miss_inc && (w_miss_sat == MISS_LIM);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!i_run) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_next = ST_FREE;
                ST_FREE:   if (i_arm) w_state_next = ST_ARMED;
                ST_ARMED:  if (w_pe) w_state_next = ST_LOCKED;
                           else if (w_timeout) w_state_next = ST_FREE;
                ST_LOCKED: if (w_loss) w_state_next = ST_FREE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_p_next         = w_wrap ? '0 : r_p + P_W'(1);
        w_m_next         = w_sec_wrap ? '0 : (w_wrap ? r_m + M_W'(1) : r_m);
        w_tick_ms_next   = w_wrap;
        w_tick_sec_next  = w_sec_wrap;
        w_miss_next      = r_miss;
        w_arm_cnt_next   = r_arm_cnt;
        w_pps_seen_next  = r_pps_seen;
        w_sync_fail_next = 1'b0;
        w_lost_next      = 1'b0;
        w_locked_next    = (w_state_next == ST_LOCKED);
        case (r_state)
            ST_IDLE: begin
                w_p_next        = '0;
                w_m_next        = '0;
                w_tick_ms_next  = 1'b0;
                w_tick_sec_next = 1'b0;
            end
            ST_FREE: begin
                if (w_state_next == ST_ARMED) w_arm_cnt_next = '0;
            end
            ST_ARMED: begin
                // The acquiring edge defines the second boundary; it also counts as this second's PPS.
                if (w_pe) begin
                    w_p_next        = '0;
                    w_m_next        = '0;
                    w_tick_ms_next  = 1'b1;
                    w_tick_sec_next = 1'b1;
                    w_miss_next     = '0;
                    w_pps_seen_next = 1'b1;
                    w_arm_cnt_next  = '0;
                end else if (w_timeout) begin
                    w_sync_fail_next = 1'b1;
                    w_arm_cnt_next   = '0;
                end else if (w_sec_wrap) begin
                    w_arm_cnt_next = r_arm_cnt + ARM_W'(1);
                end
            end
            ST_LOCKED: begin
                if (w_good) w_miss_next = '0;
                else if (w_miss_inc) w_miss_next = w_miss_sat;
                if (w_close) w_pps_seen_next = 1'b0;
                else if (w_good) w_pps_seen_next = 1'b1;
                w_lost_next = w_loss;
`ifdef TIMEBASE_DRIFT_CORRECT_EN
                if (w_good && w_in_early) begin
                    w_p_next        = '0;
                    w_m_next        = '0;
                    w_tick_ms_next  = 1'b1;
                    w_tick_sec_next = 1'b1;
                end else if (w_good && w_in_late && !w_wrap) begin
                    w_p_next = '0;
                end
`endif
            end
            default: ;
        endcase
        if (!i_run) begin
            w_p_next         = '0;
            w_m_next         = '0;
            w_tick_ms_next   = 1'b0;
            w_tick_sec_next  = 1'b0;
            w_miss_next      = '0;
            w_arm_cnt_next   = '0;
            w_pps_seen_next  = 1'b0;
            w_sync_fail_next = 1'b0;
            w_lost_next      = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p         <= '0;
            r_m         <= '0;
            r_miss      <= '0;
            r_arm_cnt   <= '0;
            r_pps_seen  <= 1'b0;
            r_tick_ms   <= 1'b0;
            r_tick_sec  <= 1'b0;
            r_locked    <= 1'b0;
            r_sync_fail <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            r_p         <= w_p_next;
            r_m         <= w_m_next;
            r_miss      <= w_miss_next;
            r_arm_cnt   <= w_arm_cnt_next;
            r_pps_seen  <= w_pps_seen_next;
            r_tick_ms   <= w_tick_ms_next;
            r_tick_sec  <= w_tick_sec_next;
            r_locked    <= w_locked_next;
            r_sync_fail <= w_sync_fail_next;
            r_lost      <= w_lost_next;
        end
    end

    assign o_tick_ms   = r_tick_ms;
    assign o_tick_sec  = r_tick_sec;
    assign o_locked    = r_locked;
    assign o_sync_fail = r_sync_fail;
    assign o_lost      = r_lost;
    assign o_state     = r_state;

endmodule

// File: doc/timebase_sync_controller.md
# timebase_sync_controller

Sequencing controller for the clock's time-base divider chain: generates the 1 ms and 1 s ticks from the system clock and disciplines them to an external 1PPS reference. It sits between the board clock and the timekeeping counters. It replaces free-running divider instances with a state machine that:
- arms on request,
- hard-aligns the second boundary to the first PPS edge,
- monitors lock,
- falls back to free-running when the reference is lost.

## Interface
Parameters:
- MS_DIV, 100000: system-clock cycles per ms tick (≥2)
- SEC_DIV, 1000: ms ticks per second tick (≥4)
- WIN, 2: half-width of the PPS acceptance window, in ms (1 ≤ WIN < SEC_DIV/2)
- MISS_MAX, 3: consecutive misses before lock is declared lost
- ARM_TIMEOUT, 4: seconds to wait for a PPS edge while armed

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- run  in  1  level; 0 forces IDLE
- arm  in  1  single-cycle request to acquire the PPS reference
- sync_in  in  1  asynchronous 1PPS input
- tick_ms  out  1  one-cycle ms strobe
- tick_sec  out  1  one-cycle second strobe; always coincident with tick_ms
- locked  out  1  high while in LOCKED
- sync_fail  out  1  one-cycle pulse on arm timeout
- lost  out  1  one-cycle pulse on loss of lock
- state  out  2  current FSM state

## Operation
- Counters:
  - Prescaler p runs 0..MS_DIV-1. When p = MS_DIV-1, p wraps to 0 and tick_ms = 1 on the next cycle.
  - ms counter m runs 0..SEC_DIV-1 and advances on each wrap.
  - When m wraps from SEC_DIV-1 to 0, tick_sec = 1 together with tick_ms.
- PPS edge: sync_in passes through a 2-FF synchronizer plus rising-edge detect, producing a one-cycle `pe`.
- States:
  - IDLE: p = m = 0; ticks held at 0.
  - FREE: counters run.
  - ARMED: counters run; the arm timer counts tick_sec pulses.
  - LOCKED: counters run; PPS is monitored.
- Transitions:
  - run = 0 in any state → IDLE. This clears the miss count, the arm timer and the pps_seen flag.
  - IDLE & run → FREE.
  - FREE & arm → ARMED, arm timer = 0. arm is ignored in IDLE, ARMED and LOCKED.
  - ARMED & pe → LOCKED. On the next cycle: p = 0, m = 0, tick_ms = tick_sec = 1, miss = 0.
  - ARMED & ARM_TIMEOUT tick_sec pulses without pe → FREE, with a sync_fail pulse. If pe arrives in the same cycle as the timeout tick_sec, pe wins.
  - LOCKED & miss reaches MISS_MAX → FREE, with a lost pulse; locked drops on the same cycle.
- Window check in LOCKED:
  - pe is good if m ≥ SEC_DIV-WIN or m < WIN. A good pe sets pps_seen and clears miss.
  - pe outside the window → miss + 1.
  - On the tick_ms where m becomes WIN: if pps_seen = 0 then miss + 1; pps_seen is then cleared.
  - A bad pe and the window-close check in the same cycle count +1 only.
- Miss counter: saturates at MISS_MAX.

## Timing
- Reset values: tick_ms = tick_sec = locked = sync_fail = lost = 0; state = IDLE; all counters 0.
- sync_in rise to pe: 3 clk (2 synchronizer stages + edge register).
- pe to the aligned tick_sec in ARMED: 1 clk.
- All outputs are registered. No combinational path from any input to any output.
- sync_fail and lost are exactly one cycle wide.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). Release resumes in IDLE.
- Periods in FREE: tick_ms period = MS_DIV clk; tick_sec period = MS_DIV·SEC_DIV clk.

## Configuration
- TIMEBASE_DRIFT_CORRECT_EN defined: a good pe in LOCKED also realigns the counters.
  - Early edge (m ≥ SEC_DIV-WIN): next cycle p = 0, m = 0, tick_ms = tick_sec = 1.
  - Late edge (m < WIN): p = 0, m unchanged, no extra tick.
  - No second is ever doubled or skipped.
- Undefined: LOCKED only monitors; the counters are never adjusted after the initial alignment.

## Structure
- Shared package timebase_pkg holds:
  - state encodings: IDLE = 0, FREE = 1, ARMED = 2, LOCKED = 3;
  - counter-width helper constants derived via $clog2.
- One sub-module, sync_edge_detect: 2-FF synchronizer plus rising-edge pulse, reset to 0.

## Test plan
All scenarios use MS_DIV = 4, SEC_DIV = 10, WIN = 2, MISS_MAX = 3, ARM_TIMEOUT = 2.
- Free run: reset release, run = 1 → tick_ms every 4 clk; tick_sec every 40 clk, coincident with every 10th tick_ms; locked = 0.
- Acquire: arm, then sync_in rises at an arbitrary phase → tick_sec exactly 4 clk after the rise (3 + 1); locked = 1; state = 3.
- Arm timeout: arm with sync_in held low → sync_fail pulse on the 2nd tick_sec after arm; state = 1.
- Lock loss: lock, then stop sync_in → lost pulse after 3 window-close checks (3rd second); locked = 0; state = 1.
- Drift correction (macro defined): lock, then PPS period of 39 clk → each early edge yields tick_sec 1 clk after pe; no double ticks; miss stays 0. With the macro undefined, the same stimulus gives no realignment.
- Reset mid-LOCKED: assert reset → all outputs 0 immediately; after release, state = 0 until run is reasserted.
